// File: rtl/vga_snake_pkg.sv
// Shared constants for the multi-player snake VGA front end:
// 640x480@60 timing, cell code encodings, colour tables and grid size.
package vga_snake_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;

   localparam int GRID_W      = 40;
   localparam int GRID_H      = 30;
   localparam int MAX_PLAYERS = 4;

   typedef enum logic [1:0] {
      CODE_NONE = 2'b00,
      CODE_BODY = 2'b01,
      CODE_HEAD = 2'b10,
      CODE_WALL = 2'b11
   } code_e;

   localparam logic [11:0] WALL_C  = 12'h888;
   localparam logic [11:0] APPLE_C = 12'hF00;
   localparam logic [11:0] BG_C    = 12'h021;

   // Index 0 is the rightmost entry.
   localparam logic [3:0][11:0] HEAD_C =
      {12'hF0F, 12'h0FF, 12'h00F, 12'h0F0};
   localparam logic [3:0][11:0] BODY_C =
      {12'h808, 12'h088, 12'h008, 12'h080};

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing: pixel clock-enable divider, h/v counters, raw syncs, active, frame_tick.
// Ports: clk, rst (async active-low) in; x_pos, y_pos, pix_en, frame_tick, hsync_raw, vsync_raw, active out.
module vga_timing_gen
   import vga_snake_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_ACT   = H_ACTIVE,
   parameter int H_FP    = H_FRONT,
   parameter int H_SW    = H_SYNC,
   parameter int H_BP    = H_BACK,
   parameter int V_ACT   = V_ACTIVE,
   parameter int V_FP    = V_FRONT,
   parameter int V_SW    = V_SYNC,
   parameter int V_BP    = V_BACK
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       pix_en,
   output logic       frame_tick,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       active
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SW + V_BP - 1);
   localparam logic [9:0] H_ACT_C = 10'(H_ACT);
   localparam logic [9:0] V_ACT_C = 10'(V_ACT);
   localparam logic [9:0] V_ACT_LAST = 10'(V_ACT - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACT + H_FP + H_SW);
   localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACT + V_FP + V_SW);

   logic [DIV_W-1:0] div;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div   <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (pix_en) begin
            div <= '0;
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               if (v_cnt == V_LAST) v_cnt <= '0;
               else                 v_cnt <= v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   assign pix_en     = (div == DIV_MAX);
   assign x_pos      = h_cnt;
   assign y_pos      = v_cnt;
   assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign hsync_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vsync_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
   assign frame_tick = pix_en && (h_cnt == H_LAST) && (v_cnt == V_ACT_LAST);

endmodule

// File: rtl/vga_multi_snake_display.sv
// N-player snake VGA front end: timing, colour compositing, per-frame hit/crash pulses, heartbeat LED.
// Ports: clk, rst (async active-low), snake_code, apple_x, apple_y in;
// x_pos, y_pos, pix_en, frame_tick, hsync, vsync, color_out, hit_flag, crash_flag, led_heartbeat out.
module vga_multi_snake_display
   import vga_snake_pkg::*;
#(
   parameter int NUM_PLAYERS      = 2,
   parameter int CLK_DIV          = 4,
   parameter int CELL_SHIFT       = 4,
   parameter int HEARTBEAT_FRAMES = 30,
   parameter int H_ACT            = H_ACTIVE,
   parameter int H_FP             = H_FRONT,
   parameter int H_SW             = H_SYNC,
   parameter int H_BP             = H_BACK,
   parameter int V_ACT            = V_ACTIVE,
   parameter int V_FP             = V_FRONT,
   parameter int V_SW             = V_SYNC,
   parameter int V_BP             = V_BACK
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*NUM_PLAYERS-1:0] snake_code,
   input  logic [6*NUM_PLAYERS-1:0] apple_x,
   input  logic [5*NUM_PLAYERS-1:0] apple_y,
   output logic [9:0]               x_pos,
   output logic [9:0]               y_pos,
   output logic                     pix_en,
   output logic                     frame_tick,
   output logic                     hsync,
   output logic                     vsync,
   output logic [11:0]              color_out,
   output logic [NUM_PLAYERS-1:0]   hit_flag,
   output logic [NUM_PLAYERS-1:0]   crash_flag,
   output logic                     led_heartbeat
);

   localparam logic [9:0] GRID_W_C = 10'(H_ACT >> CELL_SHIFT);
   localparam logic [9:0] GRID_H_C = 10'(V_ACT >> CELL_SHIFT);

   localparam int HB_W = (HEARTBEAT_FRAMES > 1) ? $clog2(HEARTBEAT_FRAMES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_FRAMES - 1);

   logic active;
   logic hs_raw;
   logic vs_raw;

   vga_timing_gen #(
      .CLK_DIV (CLK_DIV),
      .H_ACT   (H_ACT),
      .H_FP    (H_FP),
      .H_SW    (H_SW),
      .H_BP    (H_BP),
      .V_ACT   (V_ACT),
      .V_FP    (V_FP),
      .V_SW    (V_SW),
      .V_BP    (V_BP)
   ) u_timing (
      .clk        (clk),
      .rst        (rst),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .pix_en     (pix_en),
      .frame_tick (frame_tick),
      .hsync_raw  (hs_raw),
      .vsync_raw  (vs_raw),
      .active     (active)
   );

   logic [9:0] cell_x;
   logic [9:0] cell_y;

   assign cell_x = x_pos >> CELL_SHIFT;
   assign cell_y = y_pos >> CELL_SHIFT;

   logic [NUM_PLAYERS-1:0] is_head;
   logic [NUM_PLAYERS-1:0] is_body;
   logic [NUM_PLAYERS-1:0] is_wall;
   logic [NUM_PLAYERS-1:0] is_apple;
   logic [NUM_PLAYERS-1:0] occ;
   logic [NUM_PLAYERS-1:0] others;
   logic [NUM_PLAYERS-1:0] hit_now;
   logic [NUM_PLAYERS-1:0] crash_now;
   logic                   any_head;
   logic                   any_body;
   logic [11:0]            head_c;
   logic [11:0]            body_c;
   logic [11:0]            pix_c;
   logic [9:0]             ax;
   logic [9:0]             ay;

   always_comb begin
      is_head   = '0;
      is_body   = '0;
      is_wall   = '0;
      is_apple  = '0;
      occ       = '0;
      others    = '0;
      hit_now   = '0;
      crash_now = '0;
      any_head  = 1'b0;
      any_body  = 1'b0;
      head_c    = BG_C;
      body_c    = BG_C;
      ax        = '0;
      ay        = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         is_head[i] = (snake_code[2*i +: 2] == CODE_HEAD);
         is_body[i] = (snake_code[2*i +: 2] == CODE_BODY);
         is_wall[i] = (snake_code[2*i +: 2] == CODE_WALL);
         ax = 10'(apple_x[6*i +: 6]);
         ay = 10'(apple_y[5*i +: 5]);
         // Out-of-grid apples can never match a visible cell.
         is_apple[i] = (ax == cell_x) && (ay == cell_y)
                    && (ax < GRID_W_C) && (ay < GRID_H_C);
      end
      occ = is_head | is_body;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (is_head[i] && !any_head) begin
            any_head = 1'b1;
            head_c   = HEAD_C[i[1:0]];
         end
         if (is_body[i] && !any_body) begin
            any_body = 1'b1;
            body_c   = BODY_C[i[1:0]];
         end
         others     = occ;
         others[i]  = 1'b0;
         hit_now[i]   = active && is_head[i] && is_apple[i];
         // A wall under the head is left to the game logic.
         crash_now[i] = active && is_head[i] && (|others);
      end
      if (|is_wall)       pix_c = WALL_C;
      else if (any_head)  pix_c = head_c;
      else if (|is_apple) pix_c = APPLE_C;
      else if (any_body)  pix_c = body_c;
      else                pix_c = BG_C;
   end

   logic [NUM_PLAYERS-1:0] hit_pend;
   logic [NUM_PLAYERS-1:0] crash_pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         color_out  <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         hit_pend   <= '0;
         crash_pend <= '0;
         hit_flag   <= '0;
         crash_flag <= '0;
      end else begin
         hit_flag   <= '0;
         crash_flag <= '0;
         if (pix_en) begin
            // Syncs share the colour stage so they stay pixel-aligned.
            color_out <= active ? pix_c : 12'h000;
            hsync     <= hs_raw;
            vsync     <= vs_raw;
            if (frame_tick) begin
               hit_flag   <= hit_pend | hit_now;
               crash_flag <= crash_pend | crash_now;
               hit_pend   <= '0;
               crash_pend <= '0;
            end else begin
               hit_pend   <= hit_pend | hit_now;
               crash_pend <= crash_pend | crash_now;
            end
         end
      end
   end

   logic [HB_W-1:0] hb_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hb_cnt        <= '0;
         led_heartbeat <= 1'b0;
      end else if (frame_tick) begin
         if (hb_cnt == HB_LAST) begin
            hb_cnt        <= '0;
            led_heartbeat <= ~led_heartbeat;
         end else begin
            hb_cnt <= hb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_multi_snake_display.sv
// Bench for vga_multi_snake_display on a shrunken raster (40x28 total, 32x24 active, 2-px cells).
// Timing model derived from the clock count; colour/sync expectations queued per pixel.
module tb_vga_multi_snake_display;
   import vga_snake_pkg::*;

   localparam int NP = 2;
   localparam int CD = 2;
   localparam int HB = 2;
   localparam int HA = 32;
   localparam int VA = 24;
   localparam int HT = 40;
   localparam int VT = 28;
   localparam int HS_LO = 34;
   localparam int HS_HI = 37;
   localparam int VS_LO = 25;
   localparam int VS_HI = 26;
   localparam int GW = 16;
   localparam int GH = 12;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic [11:0] c;
      logic        hs;
      logic        vs;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [2*NP-1:0]  snake_code;
   logic [6*NP-1:0]  apple_x;
   logic [5*NP-1:0]  apple_y;
   logic [9:0]       x_pos;
   logic [9:0]       y_pos;
   logic             pix_en;
   logic             frame_tick;
   logic             hsync;
   logic             vsync;
   logic [11:0]      color_out;
   logic [NP-1:0]    hit_flag;
   logic [NP-1:0]    crash_flag;
   logic             led_heartbeat;

   int   checks = 0;
   int   errors = 0;
   int   cnt;
   int   mh;
   int   mv;
   logic mpe;
   logic mtick;
   logic scene_on = 1'b0;
   int   ax[2] = '{0, 0};
   int   ay[2] = '{0, 0};
   exp_t sb[$];

   vga_multi_snake_display #(
      .NUM_PLAYERS      (NP),
      .CLK_DIV          (CD),
      .CELL_SHIFT       (1),
      .HEARTBEAT_FRAMES (HB),
      .H_ACT (32), .H_FP (2), .H_SW (4), .H_BP (2),
      .V_ACT (24), .V_FP (1), .V_SW (2), .V_BP (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .snake_code    (snake_code),
      .apple_x       (apple_x),
      .apple_y       (apple_y),
      .x_pos         (x_pos),
      .y_pos         (y_pos),
      .pix_en        (pix_en),
      .frame_tick    (frame_tick),
      .hsync         (hsync),
      .vsync         (vsync),
      .color_out     (color_out),
      .hit_flag      (hit_flag),
      .crash_flag    (crash_flag),
      .led_heartbeat (led_heartbeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= 0;
      else      cnt <= cnt + 1;
   end

   always_comb begin
      mh    = (cnt / CD) % HT;
      mv    = (cnt / CD / HT) % VT;
      mpe   = (cnt % CD) == CD - 1;
      mtick = mpe && mh == HT - 1 && mv == VA - 1;
   end

   function automatic logic [1:0] scene_code(int p, int cx, int cy);
      if (!scene_on) return 2'b00;
      if (p == 0) begin
         if ((cx == 5 && cy == 3) || (cx == 10 && cy == 10)) return 2'b10;
         if (cx == 6 && cy == 3) return 2'b01;
         if (cx == 17 && cy == 2) return 2'b01;
      end else begin
         if (cx == 0 && cy == 0) return 2'b11;
         if (cx == 10 && cy == 10) return 2'b01;
         if (cx == 12 && cy == 8) return 2'b10;
         if (cx == 7 && cy == 3) return 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic bit apple_on(int p, int cx, int cy);
      return ax[p] < GW && ay[p] < GH && ax[p] == cx && ay[p] == cy;
   endfunction

   function automatic exp_t exp_pix(int h, int v);
      exp_t e;
      logic [1:0] c0;
      logic [1:0] c1;
      int cx;
      int cy;
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.hs = !(h >= HS_LO && h <= HS_HI);
      e.vs = !(v >= VS_LO && v <= VS_HI);
      e.c  = 12'h000;
      if (h < HA && v < VA) begin
         cx = h / 2;
         cy = v / 2;
         c0 = scene_code(0, cx, cy);
         c1 = scene_code(1, cx, cy);
         if (c0 == 2'b11 || c1 == 2'b11) e.c = WALL_C;
         else if (c0 == 2'b10)          e.c = HEAD_C[0];
         else if (c1 == 2'b10)          e.c = HEAD_C[1];
         else if (apple_on(0, cx, cy))  e.c = APPLE_C;
         else if (apple_on(1, cx, cy))  e.c = APPLE_C;
         else if (c0 == 2'b01)          e.c = BODY_C[0];
         else if (c1 == 2'b01)          e.c = BODY_C[1];
         else                           e.c = BG_C;
      end
      return e;
   endfunction

   always_comb begin
      snake_code = {scene_code(1, mh / 2, mv / 2), scene_code(0, mh / 2, mv / 2)};
      apple_x    = {6'(ax[1]), 6'(ax[0])};
      apple_y    = {5'(ay[1]), 5'(ay[0])};
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (hsync !== 1'b1 || vsync !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync got hs=%b vs=%b want 1 1", hsync, vsync);
      end
      checks++;
      if (color_out !== 12'h000) begin
         errors++;
         $display("FAIL reset_color got %h want 000", color_out);
      end
      checks++;
      if (hit_flag !== 2'b00 || crash_flag !== 2'b00 || led_heartbeat !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got %b %b %b want 00 00 0",
                  hit_flag, crash_flag, led_heartbeat);
      end
      checks++;
      if (pix_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_pix_en got %b want 0", pix_en);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (x_pos !== 10'd0 || y_pos !== 10'd0) begin
         errors++;
         $display("FAIL reset_pos got (%0d,%0d) want (0,0)", x_pos, y_pos);
      end
   endtask

   task automatic test_timing();
      int n = 0;
      int ticks = 0;
      int pe_cnt = 0;
      int hs_low = 0;
      int vs_low = 0;
      int first_hs = -1;
      int last_pe = -1;
      while (ticks < 2 && n < 6000) begin
         @(negedge clk);
         n++;
         checks++;
         if (pix_en !== mpe) begin
            errors++;
            $display("FAIL pix_en cyc %0d got %b want %b", n, pix_en, mpe);
         end
         checks++;
         if (frame_tick !== mtick) begin
            errors++;
            $display("FAIL frame_tick cyc %0d got %b want %b", n, frame_tick, mtick);
         end
         if (pix_en) begin
            if (last_pe >= 0) begin
               checks++;
               if (n - last_pe != CD) begin
                  errors++;
                  $display("FAIL pix_period got %0d want %0d", n - last_pe, CD);
               end
            end
            last_pe = n;
            checks++;
            if (x_pos !== 10'(mh) || y_pos !== 10'(mv)) begin
               errors++;
               $display("FAIL pos got (%0d,%0d) want (%0d,%0d)", x_pos, y_pos, mh, mv);
            end
            if (ticks == 1) begin
               pe_cnt++;
               if (!hsync) hs_low++;
               if (!vsync) vs_low++;
               if (!hsync && first_hs < 0) first_hs = int'(x_pos);
            end
         end
         if (frame_tick) ticks++;
      end
      checks++;
      if (ticks < 2) begin
         errors++;
         $display("FAIL timing_timeout got %0d ticks want 2", ticks);
      end
      checks++;
      if (pe_cnt != HT * VT) begin
         errors++;
         $display("FAIL frame_len got %0d want %0d", pe_cnt, HT * VT);
      end
      checks++;
      if (hs_low != 4 * VT || vs_low != 2 * HT) begin
         errors++;
         $display("FAIL sync_len got hs %0d vs %0d want %0d %0d",
                  hs_low, vs_low, 4 * VT, 2 * HT);
      end
      checks++;
      if (first_hs != HS_LO + 1) begin
         errors++;
         $display("FAIL hsync_start got %0d want %0d", first_hs, HS_LO + 1);
      end
   endtask

   task automatic test_frames();
      int n = 0;
      logic [1:0] fl_h = 2'b00;
      logic [1:0] fl_c = 2'b00;
      exp_t e;
      do begin
         @(negedge clk);
         n++;
      end while (!mtick && n < 3000);
      checks++;
      if (!mtick) begin
         errors++;
         $display("FAIL frames_align got no tick want tick");
         return;
      end
      scene_on = 1'b1;
      ax = '{5, 3};
      ay = '{3, 9};
      sb.delete();
      sb.push_back(exp_pix(mh, mv));
      for (int f = 0; f < 2; f++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               if (color_out !== e.c) begin
                  errors++;
                  $display("FAIL color (%0d,%0d) got %h want %h", e.h, e.v, color_out, e.c);
               end
               checks++;
               if (hsync !== e.hs || vsync !== e.vs) begin
                  errors++;
                  $display("FAIL syncs (%0d,%0d) got %b%b want %b%b",
                           e.h, e.v, hsync, vsync, e.hs, e.vs);
               end
            end
            checks++;
            if (hit_flag !== fl_h || crash_flag !== fl_c) begin
               errors++;
               $display("FAIL flags f%0d got hit %b crash %b want %b %b",
                        f, hit_flag, crash_flag, fl_h, fl_c);
            end
            fl_h = 2'b00;
            fl_c = 2'b00;
            if (mpe) sb.push_back(exp_pix(mh, mv));
            if (mtick) begin
               fl_h = (f == 0) ? 2'b01 : 2'b10;
               fl_c = 2'b01;
            end
         end while (!mtick && n < 3000);
         checks++;
         if (!mtick) begin
            errors++;
            $display("FAIL frames_timeout f%0d got no tick want tick", f);
         end
         ax = '{5, 12};
         ay = '{30, 8};
      end
      @(negedge clk);
      checks++;
      if (hit_flag !== fl_h || crash_flag !== fl_c) begin
         errors++;
         $display("FAIL flags_last got hit %b crash %b want %b %b",
                  hit_flag, crash_flag, fl_h, fl_c);
      end
   endtask

   task automatic test_heartbeat();
      int n = 0;
      int ticks = 0;
      logic exp_led;
      while (!(mv == 22 && mh == 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      scene_on = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (led_heartbeat !== 1'b0 || hit_flag !== 2'b00 || crash_flag !== 2'b00) begin
         errors++;
         $display("FAIL midframe_reset got led %b hit %b crash %b want 0 00 00",
                  led_heartbeat, hit_flag, crash_flag);
      end
      rst = 1'b1;
      n = 0;
      while (ticks < 6 && n < 20000) begin
         @(negedge clk);
         n++;
         exp_led = 1'((ticks / HB) % 2);
         checks++;
         if (led_heartbeat !== exp_led) begin
            errors++;
            $display("FAIL led tick %0d got %b want %b", ticks, led_heartbeat, exp_led);
         end
         checks++;
         if (hit_flag !== 2'b00 || crash_flag !== 2'b00) begin
            errors++;
            $display("FAIL stale_flags got hit %b crash %b want 00 00", hit_flag, crash_flag);
         end
         if (mtick) ticks++;
      end
      checks++;
      if (ticks < 6) begin
         errors++;
         $display("FAIL hb_timeout got %0d ticks want 6", ticks);
      end
      @(negedge clk);
      checks++;
      if (led_heartbeat !== 1'b1) begin
         errors++;
         $display("FAIL led_after6 got %b want 1", led_heartbeat);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (led_heartbeat !== 1'b0) begin
         errors++;
         $display("FAIL led_reset got %b want 0", led_heartbeat);
      end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      test_reset();
      test_timing();
      test_frames();
      test_heartbeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
